// File: rtl/noc_fifo_pkg.sv
// rtl/noc_fifo_pkg.sv - width helpers and packed-count access for the VC stream FIFO
package noc_fifo_pkg;

  // Widest packed count vector the slice helper accepts.
  localparam int unsigned MAX_PACKED = 256;

  // Bits needed to index n entries, never less than one.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A count must represent 0..depth inclusive, so it needs one more bit than a pointer.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

  // Extract one VC's occupancy from a packed count vector (VC0 in the LSBs).
  function automatic int unsigned cnt_slice(input logic [MAX_PACKED-1:0] packed_cnt,
                                            input int unsigned vc, input int unsigned w);
    logic [MAX_PACKED-1:0] sh;
    logic [MAX_PACKED-1:0] mask;
    sh   = packed_cnt >> (vc * w);
    mask = (MAX_PACKED'(1) << w) - MAX_PACKED'(1);
    return 32'(sh & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at a rotating pointer
module rr_arbiter
  import noc_fifo_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // Scan N positions from ptr_i upward with wrap; the first requester wins.
  always_comb begin
    int unsigned idx;
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = IW'(idx);
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_stream_fifo.sv
// rtl/vc_stream_fifo.sv - multi-VC circular stream buffer with round-robin locked output
module vc_stream_fifo
  import noc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned AFULL_THRESH = FIFO_DEPTH - 2,
  parameter int unsigned VC_WIDTH     = ptr_width(NUM_VC),
  parameter int unsigned ADDR_WIDTH   = ptr_width(FIFO_DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             arstn_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic [VC_WIDTH-1:0]              vc_i,
  input  logic                             valid_i,
  output logic [NUM_VC-1:0]                ready_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic [VC_WIDTH-1:0]              vc_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  input  logic [NUM_VC-1:0]                flush_i,
  output logic [NUM_VC-1:0]                almost_full_o,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned MW = ptr_width(NUM_VC * FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [NUM_VC*FIFO_DEPTH];

  logic [NUM_VC-1:0][ADDR_WIDTH-1:0] wr_ptr;
  logic [NUM_VC-1:0][ADDR_WIDTH-1:0] rd_ptr;
  logic [NUM_VC-1:0] non_empty;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] rd_en;
  logic [NUM_VC-1:0] arb_oh;
  logic [VC_WIDTH-1:0] arb_idx;
  logic arb_valid;

  logic lock_q, lock_d;
  logic [VC_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic [VC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_VC-1:0] sel_oh;
  logic [VC_WIDTH-1:0] sel_vc;
  logic fire;
  logic [MW-1:0] wr_addr;
  logic [MW-1:0] rd_addr;

  rr_arbiter #(.N(NUM_VC), .IW(VC_WIDTH)) u_arb (
    .req_i       (non_empty),
    .ptr_i       (rr_ptr_q),
    .gnt_oh_o    (arb_oh),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // A held lock overrides the arbiter so the presented word cannot change mid-handshake.
  always_comb begin
    sel_vc = lock_q ? lock_vc_q : arb_idx;
    sel_oh = arb_oh;
    if (lock_q) begin
      sel_oh            = '0;
      sel_oh[lock_vc_q] = 1'b1;
    end
  end

  assign valid_o = lock_q | arb_valid;
  assign vc_o    = sel_vc;
  assign fire    = valid_o & ready_i;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Fullness comes from the registered count only, so a full VC refuses even a same-cycle read.
    assign wr_en[v] = valid_i && (vc_i == VC_WIDTH'(v)) && (cnt_q != FULL_CNT) && !flush_i[v];
    assign rd_en[v] = fire && sel_oh[v] && !flush_i[v];

    // Pointer/count next state; flush clears the VC and swallows any same-cycle write or read.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i[v]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (wr_en[v]) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_en[v]) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        if (wr_en[v] && !rd_en[v])      cnt_d = cnt_q + CW'(1);
        else if (!wr_en[v] && rd_en[v]) cnt_d = cnt_q - CW'(1);
      end
    end

    // Per-VC pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    assign wr_ptr[v]               = wr_ptr_q;
    assign rd_ptr[v]               = rd_ptr_q;
    assign non_empty[v]            = (cnt_q != '0);
    assign ready_o[v]              = (cnt_q != FULL_CNT);
    assign almost_full_o[v]        = (32'(cnt_q) >= AFULL_THRESH);
    assign count_o[v*CW +: CW]     = cnt_q;
  end

  // Flat storage addresses: VC v owns entries v*FIFO_DEPTH .. v*FIFO_DEPTH+FIFO_DEPTH-1.
  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (wr_en[v])  wr_addr = MW'(v * FIFO_DEPTH + 32'(wr_ptr[v]));
      if (sel_oh[v]) rd_addr = MW'(v * FIFO_DEPTH + 32'(rd_ptr[v]));
    end
  end

  // Single write port: vc_i names one target, so at most one VC accepts per cycle.
  always_ff @(posedge clk_i) begin
    if (|wr_en) mem_q[wr_addr] <= data_i;
  end

  assign data_o = mem_q[rd_addr];

  // Lock/round-robin next state: hold on stall, release on handshake or when the held VC is flushed.
  always_comb begin
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    if (|(sel_oh & flush_i)) begin
      lock_d = 1'b0;
    end else if (fire) begin
      lock_d   = 1'b0;
      rr_ptr_d = (sel_vc == VC_WIDTH'(NUM_VC - 1)) ? '0 : sel_vc + VC_WIDTH'(1);
    end else if (valid_o) begin
      lock_d    = 1'b1;
      lock_vc_d = sel_vc;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_vc_stream_fifo.sv
// tb/tb_vc_stream_fifo.sv - directed and randomized checks of vc_stream_fifo against a queue model
module tb_vc_stream_fifo;
  import noc_fifo_pkg::*;

  localparam int NV = 4;
  localparam int D  = 8;
  localparam int D5 = 5;

  logic clk;
  logic arstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] data_i, data_o;
  logic [1:0]  vc_i, vc_o;
  logic        valid_i, valid_o, ready_i;
  logic [3:0]  ready_o, flush_i, afull_o;
  logic [15:0] count_o;

  logic [31:0] d5_data_i, d5_data_o;
  logic [1:0]  d5_vc_i, d5_vc_o;
  logic        d5_valid_i, d5_valid_o, d5_ready_i;
  logic [3:0]  d5_ready_o, d5_flush_i, d5_afull_o;
  logic [15:0] d5_count_o;

  vc_stream_fifo dut (
    .clk_i(clk), .arstn_i(arstn), .data_i(data_i), .vc_i(vc_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .vc_o(vc_o), .valid_o(valid_o), .ready_i(ready_i),
    .flush_i(flush_i), .almost_full_o(afull_o), .count_o(count_o)
  );

  vc_stream_fifo #(.FIFO_DEPTH(D5)) dut5 (
    .clk_i(clk), .arstn_i(arstn), .data_i(d5_data_i), .vc_i(d5_vc_i), .valid_i(d5_valid_i),
    .ready_o(d5_ready_o), .data_o(d5_data_o), .vc_o(d5_vc_o), .valid_o(d5_valid_o),
    .ready_i(d5_ready_i), .flush_i(d5_flush_i), .almost_full_o(d5_afull_o), .count_o(d5_count_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mq [NV][$];
  int m_rr;
  bit m_lock;
  int m_lvc;
  int fired [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output choice from the spec rules: locked VC, else first non-empty VC from rr upward.
  function automatic int model_grant();
    if (m_lock) return m_lvc;
    for (int i = 0; i < NV; i++) begin
      if (mq[(m_rr + i) % NV].size() > 0) return (m_rr + i) % NV;
    end
    return -1;
  endfunction

  task automatic do_reset();
    arstn = 1'b0;
    valid_i = 0; vc_i = 0; data_i = 0; ready_i = 0; flush_i = 0;
    d5_valid_i = 0; d5_vc_i = 0; d5_data_i = 0; d5_ready_i = 0; d5_flush_i = 0;
    for (int c = 0; c < NV; c++) mq[c].delete();
    m_rr = 0; m_lock = 0; m_lvc = 0;
    fired.delete();
    @(negedge clk);
    check("rst ready_o", 64'(ready_o), 64'hF);
    check("rst valid_o", 64'(valid_o), 64'h0);
    check("rst almost_full_o", 64'(afull_o), 64'h0);
    check("rst count_o", 64'(count_o), 64'h0);
    check("rst vc_o", 64'(vc_o), 64'h0);
    check("rst d5 count_o", 64'(d5_count_o), 64'h0);
    arstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: drive inputs, check all outputs against the model, then advance the model.
  task automatic cyc(input bit v, input int vc, input logic [31:0] d, input bit rdy,
                     input logic [3:0] fl);
    int g;
    bit accept;
    valid_i = v; vc_i = 2'(vc); data_i = d; ready_i = rdy; flush_i = fl;
    @(negedge clk);
    g = model_grant();
    for (int c = 0; c < NV; c++) begin
      check($sformatf("ready_o[%0d]", c), 64'(ready_o[c]), 64'(mq[c].size() != D));
      check($sformatf("almost_full_o[%0d]", c), 64'(afull_o[c]), 64'(mq[c].size() >= D - 2));
      check($sformatf("count[%0d]", c), 64'(cnt_slice(MAX_PACKED'(count_o), c, 4)),
            64'(mq[c].size()));
    end
    check("valid_o", 64'(valid_o), 64'(g >= 0));
    if (g >= 0) begin
      check("vc_o", 64'(vc_o), 64'(g));
      check("data_o", 64'(data_o), 64'(mq[g][0]));
    end
    accept = v && (mq[vc].size() != D) && !fl[vc];
    if ((g >= 0) && rdy && !fl[g]) fired.push_back(g);
    for (int c = 0; c < NV; c++) if (fl[c]) mq[c].delete();
    if (g >= 0) begin
      if (fl[g]) m_lock = 0;
      else if (rdy) begin
        void'(mq[g].pop_front());
        m_lock = 0;
        m_rr = (g + 1) % NV;
      end else begin
        m_lock = 1;
        m_lvc = g;
      end
    end
    if (accept) mq[vc].push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic check_fired(input string tag, input int exp_seq [$]);
    check({tag, " len"}, 64'(fired.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < fired.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(fired[i]), 64'(exp_seq[i]));
  endtask

  logic [31:0] q5 [$];

  initial begin
    // Three words through VC2.
    do_reset();
    cyc(1, 2, 32'hA, 1, 0);
    cyc(1, 2, 32'hB, 1, 0);
    cyc(1, 2, 32'hC, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    check_fired("vc2 order", '{2, 2, 2});

    // Fill VC1, then one extra write that must be dropped.
    do_reset();
    for (int i = 0; i < D; i++) cyc(1, 1, 32'h100 + 32'(i), 0, 0);
    cyc(1, 1, 32'hDEAD, 0, 0);
    check("full ready_o", 64'(ready_o), 64'hD);
    check("full almost_full_o", 64'(afull_o), 64'h2);
    check("full count1", 64'(cnt_slice(MAX_PACKED'(count_o), 1, 4)), 64'd8);
    repeat (D + 1) cyc(0, 0, 0, 1, 0);
    check_fired("full drain", '{1, 1, 1, 1, 1, 1, 1, 1});

    // Round-robin over two words in every VC.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NV; c++) cyc(1, c, 32'h200 + 32'(k * 4 + c), 0, 0);
    fired.delete();
    repeat (9) cyc(0, 0, 0, 1, 0);
    check_fired("rr order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // Lock held on VC0 while VC1 arrives; VC1 is next after release.
    do_reset();
    cyc(1, 0, 32'h10, 0, 0);
    cyc(1, 3, 32'h13, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 32'h11, 0, 0);
    check("lock vc_o", 64'(vc_o), 64'd0);
    check("lock data_o", 64'(data_o), 64'h10);
    fired.delete();
    repeat (4) cyc(0, 0, 0, 1, 0);
    check_fired("lock order", '{0, 1, 3});

    // Flush a full, locked VC3 with a concurrent write and ready.
    do_reset();
    for (int i = 0; i < D; i++) cyc(1, 3, 32'h300 + 32'(i), 0, 0);
    cyc(1, 3, 32'hBAD, 1, 4'b1000);
    check("flush count3", 64'(cnt_slice(MAX_PACKED'(count_o), 3, 4)), 64'd0);
    check("flush ready3", 64'(ready_o[3]), 64'd1);
    check("flush valid_o", 64'(valid_o), 64'd0);
    cyc(1, 0, 32'h55, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check_fired("post-flush", '{0});

    // Randomized traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom,
          $urandom_range(0, 2) != 0, fl);
    end

    // Depth-5 instance: 12 interleaved writes/reads on VC0 across pointer wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bit w, r, acc;
      w = (i < 12);
      r = (i >= 12) || (i % 2 == 1);
      d5_valid_i = w; d5_vc_i = 0; d5_data_i = 32'h500 + 32'(i); d5_ready_i = r;
      @(negedge clk);
      check("d5 count0", 64'(cnt_slice(MAX_PACKED'(d5_count_o), 0, 4)), 64'(q5.size()));
      check("d5 ready_o", 64'(d5_ready_o), 64'({3'b111, q5.size() != D5}));
      check("d5 almost_full_o", 64'(d5_afull_o), 64'({3'b000, q5.size() >= D5 - 2}));
      check("d5 valid_o", 64'(d5_valid_o), 64'(q5.size() > 0));
      if (q5.size() > 0) begin
        check("d5 data_o", 64'(d5_data_o), 64'(q5[0]));
        check("d5 vc_o", 64'(d5_vc_o), 64'd0);
      end
      acc = w && (q5.size() != D5);
      if (r && q5.size() > 0) void'(q5.pop_front());
      if (acc) q5.push_back(d5_data_i);
      @(posedge clk); #1;
    end
    check("d5 drained valid_o", 64'(d5_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_stream_fifo.md
# vc_stream_fifo

Multi-channel successor to the single-lane stream FIFO: NUM_VC independent circular buffers share one input stream and one output stream, with the target channel selected by a VC tag on input. Output is granted round-robin among non-empty channels and locked until the handshake completes. Adds per-channel almost-full, occupancy and synchronous flush. Sits at NoC router input ports as the virtual-channel buffer ahead of route computation.

## Interface
- DATA_WIDTH, 32, payload width
- FIFO_DEPTH, 8, entries per VC, any value ≥ 2 (non-power-of-2 legal)
- NUM_VC, 4, number of virtual channels, ≥ 2
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count ≥ this
- VC_WIDTH, $clog2(NUM_VC), derived
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived
- clk_i  input  1  clock, all state on rising edge
- arstn_i  input  1  reset, asynchronous, active-low
- data_i  input  DATA_WIDTH  write payload
- vc_i  input  VC_WIDTH  target VC of write
- valid_i  input  1  write request
- ready_o  output  NUM_VC  per-VC not-full
- data_o  output  DATA_WIDTH  head word of granted VC
- vc_o  output  VC_WIDTH  granted VC
- valid_o  output  1  some VC granted
- ready_i  input  1  downstream accepts
- flush_i  input  NUM_VC  per-VC synchronous clear
- almost_full_o  output  NUM_VC  count ≥ AFULL_THRESH
- count_o  output  NUM_VC*(ADDR_WIDTH+1)  packed per-VC occupancy, VC0 in LSBs

## Operation
- Write accepted iff valid_i && ready_o[vc_i] && !flush_i[vc_i]; word stored at that VC's write pointer, pointer wraps FIFO_DEPTH-1 → 0.
- ready_o[v] = count[v] != FIFO_DEPTH; depends on count only, so a full VC refuses a write even when read in the same cycle.
- Arbiter: combinational search over non-empty VCs from rr_ptr upward, wrapping; first hit is grant. valid_o = any non-empty VC (or lock held).
- Lock: if valid_o && !ready_i, grant registered (lock flag + locked VC); next cycles present same VC regardless of rr_ptr until handshake. data_o/vc_o stable while locked.
- Read handshake valid_o && ready_i: granted VC read pointer advances (wrap as write), lock clears, rr_ptr <= (grant+1) mod NUM_VC.
- Count per VC: +1 on write only, −1 on read only, unchanged on both.
- flush_i[v]: pointers and count of v → 0 next edge; overrides simultaneous write/read on v (write dropped, read not counted, rr_ptr unchanged); drops lock if locked VC == v. Downstream must not complete a handshake on a VC it flushes in the same cycle — flush wins.
- Memory not reset; output data from empty/flushed VC is don't-care.

## Timing
- Reset: all counts 0, pointers 0, rr_ptr 0, lock 0; ready_o all 1, valid_o 0, almost_full_o all 0 (for AFULL_THRESH > 0), count_o 0, vc_o 0.
- Write→valid_o latency 1 cycle (word accepted at edge N visible after edge N).
- Read throughput 1 word/cycle; full-rate concurrent write and read on different or same VC.
- ready_o, almost_full_o, count_o are registered-state functions only (no input→output comb path); valid_o/data_o/vc_o comb from state only; ready_i has no comb path to any output.
- Reset mid-operation clears everything asynchronously; contents lost.

## Structure
- Package noc_fifo_pkg: count/pointer width helper functions, packed-count slice function.
- Sub-module rr_arbiter (NUM_VC request vector, rr_ptr in, one-hot + index grant out); pointer/lock update stays in top.
- Per-VC storage via generate loop; one array of NUM_VC×FIFO_DEPTH words.

## Test plan
- Reset, then write 3 words to VC2 (0xA,0xB,0xC), ready_i=1 → out 0xA,0xB,0xC with vc_o=2 on consecutive cycles, valid_o 1 cycle after first write.
- Fill VC1 with FIFO_DEPTH words, ready_i=0 → ready_o[1]=0, others 1, almost_full_o[1] from count 6 (defaults), count_o[1]=8; extra write dropped.
- Preload 2 words in each of VC0..3, ready_i=1 → vc_o sequence 0,1,2,3,0,1,2,3.
- Preload VC0 and VC3, ready_i=0 for 3 cycles with grant VC0, then write VC1 → vc_o stays 0 until ready_i=1, next grant VC1.
- Fill VC3, assert flush_i[3] with concurrent write and ready_i=1 while locked on VC3 → count_o[3]=0, ready_o[3]=1, lock dropped, write discarded.
- Non-power-of-2 FIFO_DEPTH=5: 12 writes/reads interleaved on VC0 → data order preserved across wrap.
